lbp_window_sched: RTL and testbench

- Read-side scheduler for the LBP datapath.
- Sequences raster reads of the IMG_W x IMG_H gray image from the host memory interface and keeps a 3-row line buffer.
- Emits one 3x3 window per centre pixel, in raster order, to a downstream LBP compute core over a valid/ready handshake.
- Tags each window with its centre address and a border flag, so the core can drive lbp_addr/lbp_data directly; asserts finish when every window has been accepted.

---
 rtl/lbp_window_sched_if.sv | 27 ++
 rtl/lbp_window_sched.sv | 194 +++++++++++++++++++
 tb/tb_lbp_window_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lbp_window_sched_if.sv
// Host-read and window-stream signals of the LBP window scheduler.
// master = scheduler side, slave = memory / compute-core side.
interface lbp_window_sched_if #(
    parameter int AW = 14,
    parameter int DW = 8
);
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic          gray_ready;
    logic [DW-1:0] gray_data;

    logic            win_valid;
    logic            win_ready;
    logic [9*DW-1:0] win_data;
    logic [AW-1:0]   win_addr;
    logic            win_border;

    modport master (
        output gray_req, gray_addr, win_valid, win_data, win_addr, win_border,
        input  gray_ready, gray_data, win_ready
    );

    modport slave (
        input  gray_req, gray_addr, win_valid, win_data, win_addr, win_border,
        output gray_ready, gray_data, win_ready
    );
endinterface

// File: rtl/lbp_window_sched.sv
// Raster read scheduler with a 3-row line buffer emitting 3x3 windows per centre pixel.
// Optional stall counters enabled by defining LBP_WINDOW_SCHED_PERF_EN.
module lbp_window_sched #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14,
    parameter int DW    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    lbp_window_sched_if.master bus,
    output logic               busy,
    output logic               finish
`ifdef LBP_WINDOW_SCHED_PERF_EN
    ,
    output logic [31:0]        rd_stall_cnt,
    output logic [31:0]        wr_stall_cnt
`endif
);

    localparam int CW  = $clog2(2 * IMG_W + 1);
    localparam int XW  = $clog2(IMG_W + 1);
    localparam int IXW = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_EMIT, S_FETCH, S_DONE} state_t;

    state_t          state;
    logic [CW-1:0]   rd_left;
    logic            cap_pend;
    logic [IXW-1:0]  wr_col;
    logic [1:0]      wr_slot;
    logic [YW-1:0]   em_row;
    logic [1:0]      cur_slot;
    logic [XW-1:0]   em_cnt;
    logic [AW-1:0]   em_addr;
    logic [AW-1:0]   gray_addr_q;
    logic            win_valid_q;
    logic [9*DW-1:0] win_data_q;
    logic [AW-1:0]   win_addr_q;
    logic            win_border_q;

    logic [DW-1:0]   lb [3][IMG_W];
    logic [9*DW-1:0] win_next;
    logic            nxt_border;
    logic [1:0]      rd_slot;
    logic [IXW-1:0]  rd_col;
    logic            start_ok;

    function automatic logic [1:0] slot_inc(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // Request is gated by gray_ready so that it never sits high against a stalled memory.
    assign bus.gray_req   = (rd_left != '0) && bus.gray_ready;
    assign bus.gray_addr  = gray_addr_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_data   = win_data_q;
    assign bus.win_addr   = win_addr_q;
    assign bus.win_border = win_border_q;

    assign start_ok = start && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clk) begin
        if (cap_pend) lb[wr_slot][wr_col] <= bus.gray_data;
    end

    // Rows r-1, r, r+1 of the emitting row live in slots cur_slot-1, cur_slot, cur_slot+1 (mod 3).
    always_comb begin
        win_next   = '0;
        rd_slot    = '0;
        rd_col     = '0;
        nxt_border = (em_cnt == '0) || (em_cnt == XW'(IMG_W - 1)) ||
                     (em_row == '0) || (em_row == YW'(IMG_H - 1));
        if (!nxt_border) begin
            for (int unsigned dy = 0; dy < 3; dy++) begin
                for (int unsigned dx = 0; dx < 3; dx++) begin
                    rd_slot = 2'((32'(cur_slot) + dy + 2) % 3);
                    rd_col  = IXW'(32'(em_cnt) + dx - 1);
                    win_next[DW*(3*dy+dx) +: DW] = lb[rd_slot][rd_col];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            rd_left      <= '0;
            cap_pend     <= 1'b0;
            wr_col       <= '0;
            wr_slot      <= '0;
            em_row       <= '0;
            cur_slot     <= '0;
            em_cnt       <= '0;
            em_addr      <= '0;
            gray_addr_q  <= '0;
            win_valid_q  <= 1'b0;
            win_data_q   <= '0;
            win_addr_q   <= '0;
            win_border_q <= 1'b0;
            busy         <= 1'b0;
            finish       <= 1'b0;
        end else begin
            cap_pend <= bus.gray_req;
            if (bus.gray_req) begin
                rd_left <= rd_left - CW'(1);
                if (gray_addr_q != LAST_ADDR) gray_addr_q <= gray_addr_q + AW'(1);
            end
            if (cap_pend) begin
                if (wr_col == IXW'(IMG_W - 1)) begin
                    wr_col  <= '0;
                    wr_slot <= slot_inc(wr_slot);
                end else begin
                    wr_col <= wr_col + IXW'(1);
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_PRIME;
                        busy        <= 1'b1;
                        finish      <= 1'b0;
                        rd_left     <= CW'(2 * IMG_W);
                        gray_addr_q <= '0;
                        wr_col      <= '0;
                        wr_slot     <= '0;
                        em_row      <= '0;
                        cur_slot    <= '0;
                        em_addr     <= '0;
                    end
                end
                S_PRIME, S_FETCH: begin
                    if (rd_left == '0 && !cap_pend) begin
                        state  <= S_EMIT;
                        em_cnt <= '0;
                    end
                end
                S_EMIT: begin
                    if (!win_valid_q || bus.win_ready) begin
                        if (em_cnt != XW'(IMG_W)) begin
                            win_valid_q  <= 1'b1;
                            win_data_q   <= win_next;
                            win_addr_q   <= em_addr;
                            win_border_q <= nxt_border;
                            em_addr      <= em_addr + AW'(1);
                            em_cnt       <= em_cnt + XW'(1);
                        end else begin
                            // Last window of the row has just been accepted.
                            win_valid_q <= 1'b0;
                            if (32'(em_row) + 2 <= IMG_H - 1) begin
                                state    <= S_FETCH;
                                rd_left  <= CW'(IMG_W);
                                em_row   <= em_row + YW'(1);
                                cur_slot <= slot_inc(cur_slot);
                            end else if (32'(em_row) < IMG_H - 1) begin
                                em_cnt   <= '0;
                                em_row   <= em_row + YW'(1);
                                cur_slot <= slot_inc(cur_slot);
                            end else begin
                                state  <= S_DONE;
                                busy   <= 1'b0;
                                finish <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LBP_WINDOW_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            rd_stall_cnt <= '0;
            wr_stall_cnt <= '0;
        end else begin
            if ((state == S_PRIME || state == S_FETCH) && rd_left != '0 &&
                !bus.gray_ready && rd_stall_cnt != '1)
                rd_stall_cnt <= rd_stall_cnt + 32'd1;
            if (win_valid_q && !bus.win_ready && wr_stall_cnt != '1)
                wr_stall_cnt <= wr_stall_cnt + 32'd1;
        end
    end
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_lbp_window_sched.sv
// Self-checking bench: 4x4 instance for directed scenarios, default 128x128 for the constant image.
module tb_lbp_window_sched;

    typedef struct {
        int          addr;
        logic        border;
        logic [71:0] data;
    } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic busy_a, finish_a, busy_b, finish_b;

    lbp_window_sched_if #(.AW(4),  .DW(8)) bus_a();
    lbp_window_sched_if #(.AW(14), .DW(8)) bus_b();

`ifdef LBP_WINDOW_SCHED_PERF_EN
    logic [31:0] rd_stall_a, wr_stall_a, rd_stall_b, wr_stall_b;
`endif

    lbp_window_sched #(.IMG_W(4), .IMG_H(4), .AW(4), .DW(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .bus(bus_a),
        .busy(busy_a), .finish(finish_a)
`ifdef LBP_WINDOW_SCHED_PERF_EN
        , .rd_stall_cnt(rd_stall_a), .wr_stall_cnt(wr_stall_a)
`endif
    );

    lbp_window_sched #(.IMG_W(128), .IMG_H(128), .AW(14), .DW(8)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .bus(bus_b),
        .busy(busy_b), .finish(finish_b)
`ifdef LBP_WINDOW_SCHED_PERF_EN
        , .rd_stall_cnt(rd_stall_b), .wr_stall_cnt(wr_stall_b)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference image: mode 0 pixel = address, mode 1 constant 50.
    function automatic logic [7:0] pix(input int x, input int y, input int w, input int mode);
        return (mode == 0) ? 8'(y * w + x) : 8'd50;
    endfunction

    function automatic win_t model_win(input int a, input int w, input int h, input int mode);
        win_t m;
        int x = a % w;
        int r = a / w;
        m.addr   = a;
        m.border = (x == 0 || x == w - 1 || r == 0 || r == h - 1);
        m.data   = '0;
        if (!m.border)
            for (int dy = 0; dy < 3; dy++)
                for (int dx = 0; dx < 3; dx++)
                    m.data[8*(3*dy+dx) +: 8] = pix(x + dx - 1, r + dy - 1, w, mode);
        return m;
    endfunction

    // ---------------- 4x4 instance environment ----------------
    win_t        expq[$];
    int          exp_gaddr, gacc, wins, acc6, bord_a, stall_done;
    logic        mon_a = 1'b0, gray_toggle = 1'b0, stall_mode = 1'b0;
    logic        a_cap = 1'b0;
    logic [3:0]  a_cap_addr = '0;
    logic        held_stall = 1'b0;
    logic [71:0] held_data, data5;
    logic [3:0]  held_addr;

    initial begin
        bus_a.gray_ready = 1'b0;
        bus_a.gray_data  = 8'hEE;
        bus_a.win_ready  = 1'b1;
        forever begin
            @(negedge clk);
            bus_a.gray_data  = a_cap ? 8'(a_cap_addr) : 8'hEE;
            bus_a.gray_ready = gray_toggle ? !bus_a.gray_ready : 1'b1;
            if (stall_mode && bus_a.win_valid && bus_a.win_addr == 4'd6 && stall_done < 5) begin
                bus_a.win_ready = 1'b0;
                stall_done++;
            end else begin
                bus_a.win_ready = 1'b1;
            end
            #1;
            a_cap      = bus_a.gray_req;
            a_cap_addr = bus_a.gray_addr;
        end
    end

    initial begin
        win_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_a) begin
                if (!bus_a.gray_ready) chk("gray_req_while_not_ready", bus_a.gray_req, 0);
                if (bus_a.gray_req) begin
                    chk("gray_addr_seq", bus_a.gray_addr, exp_gaddr);
                    chk("fetch_emit_overlap", bus_a.win_valid, 0);
                    exp_gaddr++;
                    gacc++;
                end
                if (held_stall) begin
                    chk("hold_valid", bus_a.win_valid, 1);
                    chk("hold_data", bus_a.win_data, held_data);
                    chk("hold_addr", bus_a.win_addr, held_addr);
                end
                if (bus_a.win_valid) begin
                    if (expq.size() == 0) begin
                        chk("extra_window", 0, 1);
                    end else begin
                        e = expq[0];
                        chk("win_addr", bus_a.win_addr, e.addr);
                        chk("win_border", bus_a.win_border, e.border);
                        chk("win_data", bus_a.win_data, e.data);
                    end
                    if (bus_a.win_ready) begin
                        if (expq.size() != 0) void'(expq.pop_front());
                        wins++;
                        if (bus_a.win_border) bord_a++;
                        if (bus_a.win_addr == 4'd6) acc6++;
                        if (bus_a.win_addr == 4'd5) data5 = bus_a.win_data;
                        held_stall = 1'b0;
                    end else begin
                        held_stall = 1'b1;
                        held_data  = bus_a.win_data;
                        held_addr  = bus_a.win_addr;
                    end
                end else begin
                    held_stall = 1'b0;
                end
            end
        end
    end

    // ---------------- 128x128 instance environment ----------------
    logic mon_b = 1'b0, b_cap = 1'b0;
    int   expb_addr = 0, bord_b = 0, gacc_b = 0;

    initial begin
        bus_b.gray_ready = 1'b1;
        bus_b.win_ready  = 1'b1;
        bus_b.gray_data  = 8'hEE;
        forever begin
            @(negedge clk);
            bus_b.gray_data = b_cap ? 8'd50 : 8'hEE;
            #1;
            b_cap = bus_b.gray_req;
        end
    end

    initial begin
        win_t m;
        forever begin
            @(negedge clk);
            #2;
            if (mon_b) begin
                if (bus_b.gray_req) begin
                    chk("b_gray_addr_seq", bus_b.gray_addr, gacc_b);
                    gacc_b++;
                end
                if (bus_b.win_valid) begin
                    m = model_win(expb_addr, 128, 128, 1);
                    chk("b_win_addr", bus_b.win_addr, expb_addr);
                    chk("b_win_border", bus_b.win_border, m.border);
                    chk("b_win_data", bus_b.win_data, m.data);
                    if (bus_b.win_border) bord_b++;
                    expb_addr++;
                end
            end
        end
    end

    // ---------------- sequencing ----------------
    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic load_frame();
        expq.delete();
        for (int a = 0; a < 16; a++) expq.push_back(model_win(a, 4, 4, 0));
        exp_gaddr  = 0;
        gacc       = 0;
        wins       = 0;
        acc6       = 0;
        bord_a     = 0;
        stall_done = 0;
        held_stall = 1'b0;
        data5      = '1;
        mon_a      = 1'b1;
    endtask

    task automatic pulse_start_a();
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("busy_after_start", busy_a, 1);
        chk("finish_cleared_after_start", finish_a, 0);
    endtask

    task automatic wait_finish_a(input int budget);
        int n = 0;
        while (!finish_a && n < budget) begin
            tick();
            n++;
        end
        chk("finish_within_budget", finish_a, 1);
    endtask

    task automatic frame_checks_a();
        chk("window_count", wins, 16);
        chk("gray_accept_count", gacc, 16);
        chk("windows_left_unsent", expq.size(), 0);
        chk("border_count", bord_a, 12);
        chk("addr5_data", data5, 72'h0a_09_08_06_05_04_02_01_00);
        chk("busy_in_done", busy_a, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        win_t p;
        // Pin the model against hand-computed windows.
        p = model_win(5, 4, 4, 0);
        chk("model_addr5", p.data, 72'h0a_09_08_06_05_04_02_01_00);
        p = model_win(10, 4, 4, 0);
        chk("model_addr10", p.data, 72'h0f_0e_0d_0b_0a_09_07_06_05);
        p = model_win(4, 4, 4, 0);
        chk("model_addr4_border", p.border, 1);
        p = model_win(129, 128, 128, 1);
        chk("model_const_interior", p.data, {9{8'd50}});

        repeat (3) tick();
        chk("rst_gray_req", bus_a.gray_req, 0);
        chk("rst_gray_addr", bus_a.gray_addr, 0);
        chk("rst_win_valid", bus_a.win_valid, 0);
        chk("rst_win_data", bus_a.win_data, 0);
        chk("rst_win_addr", bus_a.win_addr, 0);
        chk("rst_win_border", bus_a.win_border, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_finish", finish_a, 0);
        reset = 1'b0;

        // 1: straight frame, with a start pulse mid-frame that must be ignored
        load_frame();
        pulse_start_a();
        repeat (6) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("busy_start_ignored", busy_a, 1);
        wait_finish_a(400);
        frame_checks_a();

        // 2: gray_ready toggling, started from DONE
        gray_toggle = 1'b1;
        load_frame();
        pulse_start_a();
        wait_finish_a(400);
        frame_checks_a();
        gray_toggle = 1'b0;

        // 3: window stall on addr 6
        stall_mode = 1'b1;
        load_frame();
        pulse_start_a();
        wait_finish_a(400);
        frame_checks_a();
        chk("addr6_accept_once", acc6, 1);
        chk("stall_cycles_applied", stall_done, 5);
`ifdef LBP_WINDOW_SCHED_PERF_EN
        chk("wr_stall_cnt", wr_stall_a, 5);
`endif
        stall_mode = 1'b0;

        // 4: reset during FETCH of row 2, then full replay
        load_frame();
        pulse_start_a();
        begin
            int n = 0;
            while (!(bus_a.gray_req && bus_a.gray_addr == 4'd9) && n < 200) begin
                tick();
                n++;
            end
            chk("reached_row2_fetch", bus_a.gray_addr, 9);
        end
        mon_a = 1'b0;
        reset = 1'b1;
        tick();
        chk("mid_rst_gray_req", bus_a.gray_req, 0);
        chk("mid_rst_gray_addr", bus_a.gray_addr, 0);
        chk("mid_rst_win_valid", bus_a.win_valid, 0);
        chk("mid_rst_win_data", bus_a.win_data, 0);
        chk("mid_rst_win_addr", bus_a.win_addr, 0);
        chk("mid_rst_win_border", bus_a.win_border, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_finish", finish_a, 0);
        reset = 1'b0;
        tick();
        load_frame();
        pulse_start_a();
        wait_finish_a(400);
        frame_checks_a();
        mon_a = 1'b0;

        // 5: default-size constant image
        mon_b = 1'b1;
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_busy_after_start", busy_b, 1);
        begin
            int n = 0;
            while (!finish_b && n < 40000) begin
                tick();
                n++;
            end
            chk("b_finish_within_budget", finish_b, 1);
        end
        chk("b_window_count", expb_addr, 16384);
        chk("b_border_count", bord_b, 508);
        chk("b_gray_accepts", gacc_b, 16384);
        chk("b_busy_in_done", busy_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
